hazard_controller: RTL and testbench

//  Pipeline sequencing controller for the 5-stage ARM core.

---
 rtl/hazard_controller.sv | 142 ++++++++++++++
 tb/tb_hazard_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// data-memory wait holds, with saturating stall/flush statistics.
module hazard_controller #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_rs2_used,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_memRead,
  input  logic             MEM_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned LU_W   = 2;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t              state_q, state_d;
  logic [LU_W-1:0]     lu_cnt_q, lu_cnt_d;
  logic                resume_lu_q, resume_lu_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

  logic hold, flush, lu, in_lu;

  assign hold  = dmem_req & ~dmem_ready;
  assign flush = MEM_branch_taken & ~hold;
  assign lu    = ID_EX_memRead & (ID_EX_rd != 5'd31) &
                 ((ID_EX_rd == IF_ID_rs1) | (IF_ID_rs2_used & (ID_EX_rd == IF_ID_rs2)));
  // A stall interrupted by a memory wait resumes once the wait ends.
  assign in_lu = (state_q == LU_STALL) | ((state_q == MEM_WAIT) & resume_lu_q);

  // Next-state and control outputs, priority hold > flush > load-use.
  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    resume_lu_d   = resume_lu_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_MEM_flush  = 1'b0;
    pipe_hold     = 1'b0;

    if (!reset) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (hold) begin
      pipe_hold   = 1'b1;
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      state_d     = MEM_WAIT;
      resume_lu_d = in_lu;
      wait_cnt_d  = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                          : wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) mem_timeout_d = 1'b1;
    end else if (flush) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      state_d      = RUN;
      lu_cnt_d     = '0;
      resume_lu_d  = 1'b0;
    end else if (in_lu) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      resume_lu_d  = 1'b0;
      if (lu_cnt_q <= LU_W'(1)) begin
        state_d  = RUN;
        lu_cnt_d = '0;
      end else begin
        state_d  = LU_STALL;
        lu_cnt_d = lu_cnt_q - LU_W'(1);
      end
    end else begin
      state_d     = RUN;
      resume_lu_d = 1'b0;
      if (lu) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        if (LU_STALL_CYCLES > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_W'(LU_STALL_CYCLES - 1);
        end
      end
    end
  end

  // State, wait tracking and saturating statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      lu_cnt_q      <= '0;
      resume_lu_q   <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      resume_lu_q   <= resume_lu_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      if ((~pc_write | pipe_hold) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller: one instance with single-cycle
// load-use and short timeout, one with two-cycle load-use and narrow counters.
module tb_hazard_controller;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs2_used;
    logic [4:0] rd;
    logic       mem_read;
    logic       br;
    logic       req;
    logic       ready;
  } in_t;

  typedef struct {
    bit         sel;
    string      tag;
    logic [6:0] ctl;
    logic       mt;
    int         st;
    int         fl;
  } exp_t;

  // ctl = {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold}
  localparam logic [6:0] RUN_C   = 7'b1100000;
  localparam logic [6:0] STALL_C = 7'b0010000;
  localparam logic [6:0] FLUSH_C = 7'b1101110;
  localparam logic [6:0] HOLD_C  = 7'b0000001;
  localparam logic [6:0] RST_C   = 7'b0001110;
  localparam in_t IDLE = '{rs1: 5'd2, rs2: 5'd3, rs2_used: 1'b1, rd: 5'd5,
                           mem_read: 1'b0, br: 1'b0, req: 1'b0, ready: 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b0;
  in_t  in_a = IDLE;
  in_t  in_b = IDLE;

  logic pcw_a, ifw_a, bub_a, iff_a, idf_a, exf_a, hold_a, mt_a;
  logic [15:0] st_a, fl_a;
  logic pcw_b, ifw_b, bub_b, iff_b, idf_b, exf_b, hold_b, mt_b;
  logic [3:0] st_b, fl_b;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_controller #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(in_a.rs1), .IF_ID_rs2(in_a.rs2), .IF_ID_rs2_used(in_a.rs2_used),
    .ID_EX_rd(in_a.rd), .ID_EX_memRead(in_a.mem_read), .MEM_branch_taken(in_a.br),
    .dmem_req(in_a.req), .dmem_ready(in_a.ready),
    .pc_write(pcw_a), .IF_ID_write(ifw_a), .ID_EX_bubble(bub_a),
    .IF_ID_flush(iff_a), .ID_EX_flush(idf_a), .EX_MEM_flush(exf_a),
    .pipe_hold(hold_a), .mem_timeout(mt_a), .stall_cnt(st_a), .flush_cnt(fl_a)
  );

  hazard_controller #(.LU_STALL_CYCLES(2), .MEM_TIMEOUT(64), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(in_b.rs1), .IF_ID_rs2(in_b.rs2), .IF_ID_rs2_used(in_b.rs2_used),
    .ID_EX_rd(in_b.rd), .ID_EX_memRead(in_b.mem_read), .MEM_branch_taken(in_b.br),
    .dmem_req(in_b.req), .dmem_ready(in_b.ready),
    .pc_write(pcw_b), .IF_ID_write(ifw_b), .ID_EX_bubble(bub_b),
    .IF_ID_flush(iff_b), .ID_EX_flush(idf_b), .EX_MEM_flush(exf_b),
    .pipe_hold(hold_b), .mem_timeout(mt_b), .stall_cnt(st_b), .flush_cnt(fl_b)
  );

  task automatic check();
    exp_t e;
    logic [6:0] ctl;
    logic mt;
    int st, fl;
    e = sb.pop_front();
    if (e.sel == 1'b0) begin
      ctl = {pcw_a, ifw_a, bub_a, iff_a, idf_a, exf_a, hold_a};
      mt = mt_a; st = int'(st_a); fl = int'(fl_a);
    end else begin
      ctl = {pcw_b, ifw_b, bub_b, iff_b, idf_b, exf_b, hold_b};
      mt = mt_b; st = int'(st_b); fl = int'(fl_b);
    end
    n_cmp++;
    assert (ctl === e.ctl) else begin
      n_fail++; $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl, e.ctl);
    end
    n_cmp++;
    assert (mt === e.mt) else begin
      n_fail++; $error("FAIL %s mem_timeout observed=%b expected=%b", e.tag, mt, e.mt);
    end
    n_cmp++;
    assert (st == e.st) else begin
      n_fail++; $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, st, e.st);
    end
    n_cmp++;
    assert (fl == e.fl) else begin
      n_fail++; $error("FAIL %s flush_cnt observed=%0d expected=%0d", e.tag, fl, e.fl);
    end
  endtask

  // Push expectation, sample on the falling edge, then advance one cycle.
  task automatic step(input bit sel, input string tag, input logic [6:0] ctl,
                      input logic mt, input int st, input int fl);
    exp_t e;
    e.sel = sel; e.tag = tag; e.ctl = ctl; e.mt = mt; e.st = st; e.fl = fl;
    sb.push_back(e);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(0, "rst_a", RST_C, 1'b0, 0, 0);
    step(1, "rst_b", RST_C, 1'b0, 0, 0);
    reset = 1'b1;

    // Instance A: single-cycle load-use, timeout after 4 held cycles.
    step(0, "a_idle", RUN_C, 1'b0, 0, 0);
    in_a.mem_read = 1'b1; in_a.rd = 5'd1; in_a.rs1 = 5'd1;
    step(0, "a_lu_rs1", STALL_C, 1'b0, 0, 0);
    in_a = IDLE;
    step(0, "a_lu_done", RUN_C, 1'b0, 1, 0);
    in_a.mem_read = 1'b1; in_a.rd = 5'd31; in_a.rs1 = 5'd31;
    step(0, "a_rd31", RUN_C, 1'b0, 1, 0);
    in_a.rd = 5'd3; in_a.rs1 = 5'd2; in_a.rs2 = 5'd3; in_a.rs2_used = 1'b0;
    step(0, "a_rs2_unused", RUN_C, 1'b0, 1, 0);
    in_a.rs2_used = 1'b1;
    step(0, "a_rs2_used", STALL_C, 1'b0, 1, 0);
    in_a = IDLE;
    step(0, "a_idle2", RUN_C, 1'b0, 2, 0);
    in_a.req = 1'b1; in_a.ready = 1'b0; in_a.br = 1'b1;
    for (int i = 0; i < 10; i++)
      step(0, $sformatf("a_hold%0d", i + 1), HOLD_C, (i >= 4) ? 1'b1 : 1'b0, 2 + i, 0);
    in_a.ready = 1'b1;
    step(0, "a_flush_after_hold", FLUSH_C, 1'b1, 12, 0);
    in_a = IDLE;
    step(0, "a_sticky_timeout", RUN_C, 1'b1, 12, 1);

    // Instance B: two-cycle load-use, 4-bit counters.
    step(1, "b_idle", RUN_C, 1'b0, 0, 0);
    in_b.mem_read = 1'b1; in_b.rd = 5'd1; in_b.rs1 = 5'd1;
    step(1, "b_lu_first", STALL_C, 1'b0, 0, 0);
    in_b = IDLE; in_b.br = 1'b1;
    step(1, "b_branch_in_stall", FLUSH_C, 1'b0, 1, 0);
    in_b = IDLE;
    step(1, "b_run_after_flush", RUN_C, 1'b0, 1, 1);
    in_b.mem_read = 1'b1; in_b.rd = 5'd1; in_b.rs1 = 5'd1;
    step(1, "b_lu2_c1", STALL_C, 1'b0, 1, 1);
    in_b = IDLE;
    step(1, "b_lu2_c2", STALL_C, 1'b0, 2, 1);
    step(1, "b_lu2_done", RUN_C, 1'b0, 3, 1);
    in_b.mem_read = 1'b1; in_b.rd = 5'd1; in_b.rs1 = 5'd1;
    step(1, "b_lu3_c1", STALL_C, 1'b0, 3, 1);
    in_b = IDLE; in_b.req = 1'b1; in_b.ready = 1'b0;
    step(1, "b_hold_in_stall", HOLD_C, 1'b0, 4, 1);
    in_b.ready = 1'b1;
    step(1, "b_resume_stall", STALL_C, 1'b0, 5, 1);
    in_b = IDLE;
    step(1, "b_run_after_resume", RUN_C, 1'b0, 6, 1);
    in_b.req = 1'b1; in_b.ready = 1'b0; in_b.br = 1'b1;
    for (int i = 0; i < 5; i++)
      step(1, $sformatf("b_hold_br%0d", i + 1), HOLD_C, 1'b0, 6 + i, 1);
    in_b.ready = 1'b1;
    step(1, "b_flush_cycle6", FLUSH_C, 1'b0, 11, 1);
    in_b = IDLE;
    step(1, "b_run_after_br", RUN_C, 1'b0, 11, 2);
    in_b.req = 1'b1; in_b.ready = 1'b0;
    for (int i = 0; i < 6; i++)
      step(1, $sformatf("b_sat%0d", i + 1), HOLD_C, 1'b0, (11 + i > 15) ? 15 : 11 + i, 2);
    reset = 1'b0;
    step(1, "b_rst_mid_wait", RST_C, 1'b0, 15, 2);
    step(1, "b_rst_cleared", RST_C, 1'b0, 0, 0);
    reset = 1'b1;
    in_b = IDLE;
    step(1, "b_run_after_rst", RUN_C, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
